// File: rtl/culsans_soc_top.sv
// culsans_soc_top: bench-level SoC shell.
//
// A single-port, 64-bit, word-addressed SRAM and a small command sequencer
// that fetches command words starting at BootAddress. It executes
// NOP / STORE / CHECK / WAIT_RTC / EXIT and reports completion on a
// tohost-style exit word. A real-time-clock input is synchronised and counts
// rising edges in a free-running 64-bit counter.
//
// Ports
//   clk_i   in   1   system clock, rising edge
//   rst_ni  in   1   asynchronous active-low reset
//   rtc_i   in   1   real-time clock, asynchronous to clk_i
//   exit_o  out  32  {code[30:0], done}; 0 until the program finishes
//
// Command word: [63:56] opcode, [55:0] operand. STORE/CHECK carry an address
// word at pc+8 and a data/expected word at pc+16.
//
// Valid/ready: the SRAM port has no back-pressure. A request (req=1) is
// always accepted on the rising edge where it is presented. Read data is
// valid during the following cycle only.

module tc_sram #(
    parameter int unsigned NumWords = 1024,
    parameter int unsigned AddrW    = 10
) (
    input  logic             clk_i,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [63:0]      wdata_i,
    output logic [63:0]      rdata_o
);
    // Contents are deliberately not reset; the bench preloads this array.
    logic [63:0] sram [NumWords];

    always_ff @(posedge clk_i) begin
        if (req_i) begin
            if (we_i) sram[addr_i] <= wdata_i;
            else      rdata_o      <= sram[addr_i];
        end
    end
endmodule

module tc_sram_wrapper #(
    parameter int unsigned NumWords = 1024,
    parameter int unsigned AddrW    = 10
) (
    input  logic             clk_i,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [63:0]      wdata_i,
    output logic [63:0]      rdata_o
);
    tc_sram #(.NumWords(NumWords), .AddrW(AddrW)) i_tc_sram (
        .clk_i   (clk_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o)
    );
endmodule

// A single cut; the generate scopes keep the array at the hierarchy path
// that preload scripts expect.
module culsans_sram #(
    parameter int unsigned NumWords = 1024,
    parameter int unsigned AddrW    = 10
) (
    input  logic             clk_i,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [63:0]      wdata_i,
    output logic [63:0]      rdata_o
);
    for (genvar i = 0; i < 1; i++) begin : gen_cut
        if (NumWords > 0) begin : gen_mem
            tc_sram_wrapper #(.NumWords(NumWords), .AddrW(AddrW)) i_tc_sram_wrapper (
                .clk_i   (clk_i),
                .req_i   (req_i),
                .we_i    (we_i),
                .addr_i  (addr_i),
                .wdata_i (wdata_i),
                .rdata_o (rdata_o)
            );
        end
    end
endmodule

module culsans_soc_top #(
    parameter bit          InclSimDTM  = 1'b0,
    parameter int unsigned NUM_WORDS   = 4**10,
    parameter logic [63:0] BootAddress = 64'h8000_0000 + 64'h10_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rtc_i,
    output logic [31:0] exit_o
);
    localparam logic [63:0] DRAMBase = 64'h8000_0000;
    localparam logic [63:0] MemBytes = 64'(NUM_WORDS) * 64'd8;
    localparam int unsigned AddrW    = $clog2(NUM_WORDS);

    localparam logic [7:0] OpNop   = 8'h00;
    localparam logic [7:0] OpStore = 8'h01;
    localparam logic [7:0] OpCheck = 8'h02;
    localparam logic [7:0] OpWait  = 8'h03;
    localparam logic [7:0] OpExit  = 8'h04;

    localparam logic [30:0] CodeBadOp    = 31'h3FF;
    localparam logic [30:0] CodeOutRange = 31'h3FE;
    localparam logic [30:0] CodeMisalign = 31'h3FD;

    // Reserved debug-module switch; has no effect on behaviour.
    wire unused_incl_sim_dtm = InclSimDTM;

    typedef enum logic [2:0] {
        FETCH, DECODE, OPA, OPB, EXEC, WAIT, HALT
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] cmd_q, cmd_d;
    logic [63:0] a_q, a_d;
    logic [63:0] d_q, d_d;
    logic [31:0] exit_q, exit_d;
    logic        run_q;

    logic             mem_req;
    logic             mem_we;
    logic [AddrW-1:0] mem_addr;
    logic [63:0]      mem_wdata;
    logic [63:0]      mem_rdata;

    logic        rtc_s1_q, rtc_s2_q, rtc_prev_q;
    logic [63:0] rtc_count_q;

    function automatic logic in_range(input logic [63:0] a);
        return (a >= DRAMBase) && ((a - DRAMBase) < MemBytes);
    endfunction

    function automatic logic [AddrW-1:0] word_idx(input logic [63:0] a);
        logic [63:0] off;
        off = (a - DRAMBase) >> 3;
        return off[AddrW-1:0];
    endfunction

    culsans_sram #(.NumWords(NUM_WORDS), .AddrW(AddrW)) i_sram (
        .clk_i   (clk_i),
        .req_i   (mem_req),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    // RTC: two synchroniser flops, then a third flop for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rtc_s1_q    <= 1'b0;
            rtc_s2_q    <= 1'b0;
            rtc_prev_q  <= 1'b0;
            rtc_count_q <= '0;
        end else begin
            rtc_s1_q   <= rtc_i;
            rtc_s2_q   <= rtc_s1_q;
            rtc_prev_q <= rtc_s2_q;
            if (rtc_s2_q && !rtc_prev_q) rtc_count_q <= rtc_count_q + 64'd1;
        end
    end

    // run_q holds off the first memory access until the first edge after
    // reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FETCH;
            pc_q    <= BootAddress;
            cmd_q   <= '0;
            a_q     <= '0;
            d_q     <= '0;
            exit_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            d_q     <= d_d;
            exit_q  <= exit_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cmd_d     = cmd_q;
        a_d       = a_q;
        d_d       = d_q;
        exit_d    = exit_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = word_idx(pc_q);
        mem_wdata = d_q;

        unique case (state_q)
            FETCH: begin
                if (run_q) begin
                    if (!in_range(pc_q)) begin
                        exit_d  = {CodeOutRange, 1'b1};
                        state_d = HALT;
                    end else begin
                        mem_req = 1'b1;
                        state_d = DECODE;
                    end
                end
            end
            DECODE: begin
                cmd_d = mem_rdata;
                unique case (mem_rdata[63:56])
                    OpNop: begin
                        pc_d    = pc_q + 64'd8;
                        state_d = FETCH;
                    end
                    OpStore, OpCheck: begin
                        if (!in_range(pc_q + 64'd8)) begin
                            exit_d  = {CodeOutRange, 1'b1};
                            state_d = HALT;
                        end else begin
                            mem_req  = 1'b1;
                            mem_addr = word_idx(pc_q + 64'd8);
                            state_d  = OPA;
                        end
                    end
                    OpWait: state_d = WAIT;
                    OpExit: begin
                        exit_d  = {mem_rdata[30:0], 1'b1};
                        state_d = HALT;
                    end
                    default: begin
                        exit_d  = {CodeBadOp, 1'b1};
                        state_d = HALT;
                    end
                endcase
            end
            OPA: begin
                a_d = mem_rdata;
                if (!in_range(pc_q + 64'd16)) begin
                    exit_d  = {CodeOutRange, 1'b1};
                    state_d = HALT;
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = word_idx(pc_q + 64'd16);
                    state_d  = OPB;
                end
            end
            OPB: begin
                d_d = mem_rdata;
                // Misalignment is reported ahead of a range violation.
                if (a_q[2:0] != 3'b000) begin
                    exit_d  = {CodeMisalign, 1'b1};
                    state_d = HALT;
                end else if (!in_range(a_q)) begin
                    exit_d  = {CodeOutRange, 1'b1};
                    state_d = HALT;
                end else if (cmd_q[63:56] == OpStore) begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = word_idx(a_q);
                    mem_wdata = mem_rdata;
                    pc_d      = pc_q + 64'd24;
                    state_d   = FETCH;
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = word_idx(a_q);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (mem_rdata != d_q) begin
                    exit_d  = {cmd_q[30:0], 1'b1};
                    state_d = HALT;
                end else begin
                    pc_d    = pc_q + 64'd24;
                    state_d = FETCH;
                end
            end
            WAIT: begin
                if (rtc_count_q >= {8'h00, cmd_q[55:0]}) begin
                    pc_d    = pc_q + 64'd8;
                    state_d = FETCH;
                end
            end
            HALT: state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    assign exit_o = exit_q;
endmodule

// File: tb/tb_culsans_soc_top.sv
// Directed testbench for culsans_soc_top. Programs are written straight into
// the SRAM array while reset is held, then the sequencer is released.

module tb_culsans_soc_top;
    logic        clk_i;
    logic        rst_ni;
    logic        rtc_i;
    logic [31:0] exit_o;

    int n_checks;
    int n_fail;

    localparam int unsigned BOOT_IDX = 32'h2_0000;  // (0x8010_0000 - 0x8000_0000) >> 3

    culsans_soc_top dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .rtc_i  (rtc_i),
        .exit_o (exit_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic put(input int unsigned off, input logic [63:0] d);
        dut.i_sram.gen_cut[0].gen_mem.i_tc_sram_wrapper.i_tc_sram.sram[BOOT_IDX + off] = d;
    endtask

    task automatic hold_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        rtc_i  = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic release_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Waits at most budget cycles for done; samples #1 after each rising edge.
    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (exit_o[0] !== 1'b1 && cycles < budget) begin
            @(posedge clk_i);
            #1;
            cycles++;
        end
    endtask

    task automatic rtc_pulse();
        @(negedge clk_i);
        rtc_i = 1'b1;
        repeat (8) @(negedge clk_i);
        rtc_i = 1'b0;
        repeat (8) @(negedge clk_i);
    endtask

    task automatic run_program(input string name, input logic [31:0] exp);
        int cyc;
        release_reset();
        wait_done(40, cyc);
        n_checks++;
        if (exit_o !== exp) begin
            n_fail++;
            $display("FAIL %s: exit_o=%h expected=%h after %0d cycles", name, exit_o, exp, cyc);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int cyc;
        hold_reset();
        put(0, 64'h0400_0000_0000_0000);
        #1;
        n_checks++;
        if (exit_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_exit: exit_o=%h expected=00000000", exit_o);
        end
        n_checks++;
        if (dut.pc_q !== 64'h8010_0000) begin
            n_fail++;
            $display("FAIL reset_pc: pc=%h expected=0000000080100000", dut.pc_q);
        end
        release_reset();
        wait_done(4, cyc);
        n_checks++;
        if (exit_o !== 32'h1) begin
            n_fail++;
            $display("FAIL exit0_latency: exit_o=%h expected=00000001 within 4 cycles", exit_o);
        end
    endtask

    task automatic test_exit_hold();
        int cyc;
        int bad;
        hold_reset();
        put(0, 64'h0400_0000_0000_0005);
        release_reset();
        wait_done(10, cyc);
        n_checks++;
        if (exit_o !== 32'h0000_000B) begin
            n_fail++;
            $display("FAIL exit5: exit_o=%h expected=0000000b", exit_o);
        end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_i);
            #1;
            if (exit_o !== 32'h0000_000B) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL exit_hold: %0d of 100 cycles differed, last exit_o=%h expected=0000000b", bad, exit_o);
        end
    endtask

    task automatic test_nop();
        hold_reset();
        put(0, 64'h0000_0000_0000_0000);
        put(1, 64'h0000_0000_0000_0000);
        put(2, 64'h0400_0000_0000_0009);
        run_program("nop_exit9", 32'h0000_0013);
    endtask

    task automatic test_store_check();
        hold_reset();
        dut.i_sram.gen_cut[0].gen_mem.i_tc_sram_wrapper.i_tc_sram.sram[1] = 64'h0;
        put(0, 64'h0100_0000_0000_0000);
        put(1, 64'h0000_0000_8000_0008);
        put(2, 64'hDEAD_BEEF_CAFE_F00D);
        put(3, 64'h0200_0000_0000_0003);
        put(4, 64'h0000_0000_8000_0008);
        put(5, 64'hDEAD_BEEF_CAFE_F00D);
        put(6, 64'h0400_0000_0000_0000);
        run_program("store_check_pass", 32'h0000_0001);
        n_checks++;
        if (dut.i_sram.gen_cut[0].gen_mem.i_tc_sram_wrapper.i_tc_sram.sram[1] !== 64'hDEAD_BEEF_CAFE_F00D) begin
            n_fail++;
            $display("FAIL store_mem: mem[1]=%h expected=deadbeefcafef00d",
                     dut.i_sram.gen_cut[0].gen_mem.i_tc_sram_wrapper.i_tc_sram.sram[1]);
        end
    endtask

    task automatic test_check_wrong();
        hold_reset();
        put(0, 64'h0100_0000_0000_0000);
        put(1, 64'h0000_0000_8000_0008);
        put(2, 64'hDEAD_BEEF_CAFE_F00D);
        put(3, 64'h0200_0000_0000_0003);
        put(4, 64'h0000_0000_8000_0008);
        put(5, 64'h0000_0000_0000_1234);
        put(6, 64'h0400_0000_0000_0000);
        run_program("check_wrong", 32'h0000_0007);
    endtask

    task automatic test_errors();
        hold_reset();
        put(0, 64'hFF00_0000_0000_0000);
        run_program("bad_opcode", 32'h0000_07FF);

        hold_reset();
        put(0, 64'h0100_0000_0000_0000);
        put(1, 64'h0000_0000_8000_0004);
        put(2, 64'h0000_0000_0000_0001);
        put(3, 64'h0400_0000_0000_0000);
        run_program("store_misaligned", 32'h0000_07FB);

        hold_reset();
        put(0, 64'h0100_0000_0000_0000);
        put(1, 64'h0000_0000_8080_0000);
        put(2, 64'h0000_0000_0000_0001);
        put(3, 64'h0400_0000_0000_0000);
        run_program("store_out_of_range", 32'h0000_07FD);

        hold_reset();
        put(0, 64'h0200_0000_0000_0011);
        put(1, 64'h0000_0000_7FFF_FFF8);
        put(2, 64'h0000_0000_0000_0000);
        put(3, 64'h0400_0000_0000_0000);
        run_program("check_below_base", 32'h0000_07FD);
    endtask

    task automatic test_wait_rtc();
        int cyc;
        hold_reset();
        put(0, 64'h0300_0000_0000_0002);
        put(1, 64'h0400_0000_0000_0000);
        release_reset();
        repeat (20) @(negedge clk_i);
        n_checks++;
        if (exit_o !== 32'h0) begin
            n_fail++;
            $display("FAIL wait_no_rtc: exit_o=%h expected=00000000", exit_o);
        end
        rtc_pulse();
        n_checks++;
        if (exit_o !== 32'h0) begin
            n_fail++;
            $display("FAIL wait_one_edge: exit_o=%h expected=00000000", exit_o);
        end
        @(negedge clk_i);
        rtc_i = 1'b1;
        @(posedge clk_i);
        #1;
        n_checks++;
        if (exit_o !== 32'h0) begin
            n_fail++;
            $display("FAIL wait_sync_latency: exit_o=%h expected=00000000", exit_o);
        end
        wait_done(12, cyc);
        n_checks++;
        if (exit_o !== 32'h1) begin
            n_fail++;
            $display("FAIL wait_two_edges: exit_o=%h expected=00000001", exit_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        int cyc;
        hold_reset();
        put(0, 64'h0300_0000_0000_0002);
        put(1, 64'h0400_0000_0000_0000);
        release_reset();
        repeat (4) @(negedge clk_i);
        rtc_pulse();
        // Assert reset away from any clock edge to exercise the async path.
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (exit_o !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_wait_reset_exit: exit_o=%h expected=00000000", exit_o);
        end
        n_checks++;
        if (dut.rtc_count_q !== 64'h0) begin
            n_fail++;
            $display("FAIL mid_wait_reset_rtc: rtc_count=%h expected=0", dut.rtc_count_q);
        end
        repeat (2) @(negedge clk_i);
        release_reset();
        rtc_pulse();
        n_checks++;
        if (exit_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rerun_one_edge: exit_o=%h expected=00000000", exit_o);
        end
        rtc_pulse();
        wait_done(12, cyc);
        n_checks++;
        if (exit_o !== 32'h1) begin
            n_fail++;
            $display("FAIL rerun_two_edges: exit_o=%h expected=00000001", exit_o);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_ni   = 1'b0;
        rtc_i    = 1'b0;
        test_reset();
        test_exit_hold();
        test_nop();
        test_store_check();
        test_check_wrong();
        test_errors();
        test_wait_rtc();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
